// File: rtl/parity_bist.sv
// parity_bist: exhaustive self-test engine for a WIDTH-input XOR block.
// Sweeps every input pattern, holds each for HOLD_CYCLES clocks, samples
// the DUT response at the end of the hold and compares it with ^pattern
// (optionally inverted when EXPECT_XNOR is set).
//
// Ports:
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   start            level; begins a sweep from IDLE or DONE
//   pattern          DUT stimulus (MSB -> A, LSB -> D)
//   dut_out          DUT response, synchronous to clk
//   busy             high while a sweep runs
//   done             high in DONE until the next start or reset
//   pass             valid while done; 1 iff no mismatches
//   err_count        mismatching patterns in the last/current sweep
//   first_fail       pattern value of the first mismatch
//   first_fail_valid at least one mismatch has been recorded
module parity_bist #(
    parameter int WIDTH       = 4,
    parameter int HOLD_CYCLES = 4,
    parameter bit EXPECT_XNOR = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] pattern,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH:0]   err_count,
    output logic [WIDTH-1:0] first_fail,
    output logic             first_fail_valid
);

    // Hold counter needs at least one bit even when HOLD_CYCLES is 1.
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [WIDTH-1:0] PAT_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [HW-1:0]    hold_cnt;
    logic [HW-1:0]    hold_nx;
    logic [WIDTH-1:0] pattern_nx;
    logic             busy_nx;
    logic             done_nx;
    logic             pass_nx;
    logic [WIDTH:0]   err_nx;
    logic [WIDTH-1:0] ff_nx;
    logic             ffv_nx;

    logic expected;
    logic mismatch;
    logic sample;

    assign expected = (^pattern) ^ EXPECT_XNOR;
    assign mismatch = (dut_out != expected);
    assign sample   = (hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            hold_cnt         <= '0;
            pattern          <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state            <= state_nx;
            hold_cnt         <= hold_nx;
            pattern          <= pattern_nx;
            busy             <= busy_nx;
            done             <= done_nx;
            pass             <= pass_nx;
            err_count        <= err_nx;
            first_fail       <= ff_nx;
            first_fail_valid <= ffv_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        hold_nx    = hold_cnt;
        pattern_nx = pattern;
        busy_nx    = busy;
        done_nx    = done;
        pass_nx    = pass;
        err_nx     = err_count;
        ff_nx      = first_fail;
        ffv_nx     = first_fail_valid;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx   = S_RUN;
                    hold_nx    = '0;
                    pattern_nx = '0;
                    busy_nx    = 1'b1;
                    done_nx    = 1'b0;
                    pass_nx    = 1'b0;
                    err_nx     = '0;
                    ff_nx      = '0;
                    ffv_nx     = 1'b0;
                end
            end
            S_RUN: begin
                // start is deliberately ignored: a sweep only ends by
                // completing or by reset.
                if (!sample) begin
                    hold_nx = hold_cnt + 1'b1;
                end else begin
                    hold_nx = '0;
                    if (mismatch) begin
                        err_nx = err_count + 1'b1;
                        if (!first_fail_valid) begin
                            ff_nx  = pattern;
                            ffv_nx = 1'b1;
                        end
                    end
                    if (pattern == PAT_LAST) begin
                        // Verdict includes this final sample.
                        pattern_nx = '0;
                        state_nx   = S_DONE;
                        busy_nx    = 1'b0;
                        done_nx    = 1'b1;
                        pass_nx    = (err_nx == '0);
                    end else begin
                        pattern_nx = pattern + 1'b1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_parity_bist.sv
// tb_parity_bist: randomized self-checking bench for parity_bist.
// Instance 0 uses defaults; instance 1 uses HOLD_CYCLES=1, EXPECT_XNOR=1.
module tb_parity_bist;

    logic clk = 1'b0;
    logic rst_n;

    logic       start_s  [2];
    logic [3:0] pattern_s[2];
    logic       dut_out_s[2];
    logic       busy_s   [2];
    logic       done_s   [2];
    logic       pass_s   [2];
    logic [4:0] err_s    [2];
    logic [3:0] ff_s     [2];
    logic       ffv_s    [2];

    int          mode_s[2];
    logic [15:0] mask_s[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural DUT: 0 = XOR, 1 = stuck-at-0, 2 = XNOR; mask flips
    // the response for selected patterns.
    function automatic logic dut_model(input logic [3:0] p,
                                       input int mode,
                                       input logic [15:0] m);
        logic b;
        case (mode)
            0:       b = (($countones(p) % 2) == 1);
            1:       b = 1'b0;
            default: b = (($countones(p) % 2) == 0);
        endcase
        return b ^ m[p];
    endfunction

    assign dut_out_s[0] = dut_model(pattern_s[0], mode_s[0], mask_s[0]);
    assign dut_out_s[1] = dut_model(pattern_s[1], mode_s[1], mask_s[1]);

    parity_bist #(.WIDTH(4), .HOLD_CYCLES(4), .EXPECT_XNOR(1'b0)) u_dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_s[0]),
        .pattern          (pattern_s[0]),
        .dut_out          (dut_out_s[0]),
        .busy             (busy_s[0]),
        .done             (done_s[0]),
        .pass             (pass_s[0]),
        .err_count        (err_s[0]),
        .first_fail       (ff_s[0]),
        .first_fail_valid (ffv_s[0])
    );

    parity_bist #(.WIDTH(4), .HOLD_CYCLES(1), .EXPECT_XNOR(1'b1)) u_h1 (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_s[1]),
        .pattern          (pattern_s[1]),
        .dut_out          (dut_out_s[1]),
        .busy             (busy_s[1]),
        .done             (done_s[1]),
        .pass             (pass_s[1]),
        .err_count        (err_s[1]),
        .first_fail       (ff_s[1]),
        .first_fail_valid (ffv_s[1])
    );

    task automatic check_idle_reset(input int i, input string name);
        checks++;
        if ({pattern_s[i], busy_s[i], done_s[i], pass_s[i], err_s[i],
             ff_s[i], ffv_s[i]} !== 17'b0) begin
            errors++;
            $display("FAIL %s inst%0d: pat=%h busy=%b done=%b pass=%b err=%0d ff=%h ffv=%b, required all zero",
                     name, i, pattern_s[i], busy_s[i], done_s[i], pass_s[i],
                     err_s[i], ff_s[i], ffv_s[i]);
        end
    endtask

    // One full sweep on instance i, checked cycle by cycle against the
    // reference: pattern n lives for hold cycles, samples completed after
    // c cycles is c/hold, verdict appears after 16*hold cycles.
    task automatic run_sweep(input int i, input int mode,
                             input logic [15:0] mask, input bit hold_start,
                             input bit pulse_mid, input string name);
        int hold;
        bit xn;
        bit mis[16];
        int total;
        int first;
        int run_err;
        int n;
        hold  = (i == 0) ? 4 : 1;
        xn    = (i == 1);
        total = 0;
        first = -1;
        for (int p = 0; p < 16; p++) begin
            logic [3:0] pv;
            bit want;
            pv     = 4'(p);
            want   = (($countones(pv) % 2) == 1) ^ xn;
            mis[p] = (dut_model(pv, mode, mask) != want);
            if (mis[p]) begin
                total++;
                if (first < 0) first = p;
            end
        end
        mode_s[i] = mode;
        mask_s[i] = mask;
        @(negedge clk);
        start_s[i] = 1'b1;
        @(negedge clk);
        if (!hold_start) start_s[i] = 1'b0;
        for (int c = 0; c < 16 * hold; c++) begin
            n = c / hold;
            run_err = 0;
            for (int p = 0; p < n; p++) run_err += mis[p] ? 1 : 0;
            checks++;
            if (pattern_s[i] !== 4'(n) || busy_s[i] !== 1'b1 ||
                done_s[i] !== 1'b0 || err_s[i] !== 5'(run_err)) begin
                errors++;
                $display("FAIL %s run c=%0d: pat=%h busy=%b done=%b err=%0d, required pat=%h busy=1 done=0 err=%0d",
                         name, c, pattern_s[i], busy_s[i], done_s[i],
                         err_s[i], 4'(n), run_err);
            end
            if (pulse_mid && c == 21) start_s[i] = 1'b1;
            if (pulse_mid && c == 23) start_s[i] = 1'b0;
            @(negedge clk);
        end
        start_s[i] = 1'b0;
        checks++;
        if (done_s[i] !== 1'b1 || busy_s[i] !== 1'b0 ||
            pass_s[i] !== (total == 0) || err_s[i] !== 5'(total) ||
            ffv_s[i] !== (first >= 0) ||
            ff_s[i] !== ((first >= 0) ? 4'(first) : 4'd0) ||
            pattern_s[i] !== 4'd0) begin
            errors++;
            $display("FAIL %s final: done=%b busy=%b pass=%b err=%0d ffv=%b ff=%h pat=%h, required done=1 busy=0 pass=%0d err=%0d ffv=%0d ff=%h pat=0",
                     name, done_s[i], busy_s[i], pass_s[i], err_s[i],
                     ffv_s[i], ff_s[i], pattern_s[i], total == 0, total,
                     first >= 0, (first >= 0) ? 4'(first) : 4'd0);
        end
        // Results must stay stable in DONE with start low.
        repeat (3) @(negedge clk);
        checks++;
        if (done_s[i] !== 1'b1 || err_s[i] !== 5'(total)) begin
            errors++;
            $display("FAIL %s hold_done: done=%b err=%0d, required done=1 err=%0d",
                     name, done_s[i], err_s[i], total);
        end
    endtask

    task automatic test_reset();
        check_idle_reset(0, "reset");
        check_idle_reset(1, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_reset(0, "idle");
    endtask

    task automatic test_correct();
        run_sweep(0, 0, 16'h0000, 1'b0, 1'b0, "correct");
    endtask

    task automatic test_stuck0();
        run_sweep(0, 1, 16'h0000, 1'b0, 1'b0, "stuck0");
    endtask

    task automatic test_xnor();
        run_sweep(0, 2, 16'h0000, 1'b0, 1'b0, "xnor_dut");
        run_sweep(1, 2, 16'h0000, 1'b0, 1'b0, "xnor_expect");
    endtask

    task automatic test_start_in_run();
        run_sweep(0, 1, 16'h0000, 1'b1, 1'b0, "start_held");
        run_sweep(0, 0, 16'h0000, 1'b0, 1'b1, "start_pulsed");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_sweep(k % 2, int'($urandom_range(0, 2)), 16'($urandom),
                      1'b0, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid();
        int budget;
        mode_s[0] = 0;
        mask_s[0] = 16'h0000;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        budget = 0;
        while (pattern_s[0] !== 4'd5 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (pattern_s[0] !== 4'd5) begin
            errors++;
            $display("FAIL reset_mid wait: pat=%h, required 5 within 200 cycles",
                     pattern_s[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        check_idle_reset(0, "reset_async");
        #1 rst_n = 1'b1;
        run_sweep(0, 0, 16'h0000, 1'b0, 1'b0, "after_reset");
    endtask

    task automatic test_hold1();
        run_sweep(1, 0, 16'h0000, 1'b0, 1'b0, "hold1_xor_dut");
        run_sweep(1, 2, 16'h0000, 1'b0, 1'b0, "hold1_pass");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_s[i] = 1'b0;
            mode_s[i]  = 0;
            mask_s[i]  = 16'h0000;
        end
        #12;
        test_reset();
        test_correct();
        test_stuck0();
        test_correct();
        test_xnor();
        test_start_in_run();
        test_reset_mid();
        test_hold1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
